instruction_fetch_unit: RTL and testbench

Fetch stage of the 5-stage RV32I pipeline. It owns the PC and issues one instruction-memory request at a time over a valid/ready handshake. It captures the variable-latency response and drives the IF/ID pipeline register consumed by decode. It obeys the hazard unit's `IF_ID_write` stall and the EX-stage branch/jump redirect, squashing stale in-flight fetches.

---
 rtl/instruction_fetch_unit_pkg.sv | 22 ++
 rtl/instruction_fetch_unit_hold_buffer.sv | 46 ++++
 rtl/instruction_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared pipeline definitions for the fetch stage. Holds the
//               fetch FSM state encoding, the canonical NOP (addi x0,x0,0)
//               and the sequential PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request issued to instruction memory
        ST_WAIT  = 2'd1,   // one request outstanding, awaiting response
        ST_HOLD  = 2'd2,   // response parked in hold buffer during a stall
        ST_DROP  = 2'd3    // awaiting the response of a squashed request
    } fetch_state_t;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;
    localparam logic [31:0] c_pc_incr   = 32'd4;

endpackage : instruction_fetch_unit_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_hold_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hold_buffer
// Description : One-entry pc/instruction holding register. Parks a fetched
//               instruction while decode is stalled.
// Ports       : clk, reset (async, active-low)
//               load     - capture in_pc/in_instr, set valid
//               drain    - entry consumed, clear valid
//               clear    - flush (dominates load and drain)
//               in_pc, in_instr  - entry to capture
//               buf_valid, buf_pc, buf_instr - current entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        buf_valid,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_instr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_pc    <= 32'd0;
            buf_instr <= c_nop_instr;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_pc    <= in_pc;
            buf_instr <= in_instr;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

endmodule : fetch_hold_buffer
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : RV32I fetch stage. Owns the PC, issues one instruction-memory
//               request at a time, captures the variable-latency response and
//               drives the IF/ID register. Honours the decode stall
//               (IF_ID_write) and EX redirects, squashing stale fetches.
// Ports       : clk, reset (async, active-low)
//               IF_ID_write              - 0 holds IF/ID
//               redirect_valid/_pc       - EX branch/jump redirect
//               imem_req_valid/_ready/_addr - request handshake
//               imem_resp_valid/_data    - response, one per accepted request
//               if_id_valid/_pc/_instr   - IF/ID register to decode
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_ID_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;

    logic        w_accept;
    logic        w_resp_wait;
    logic        w_buf_load;
    logic        w_buf_drain;
    logic        w_buf_valid;
    logic [31:0] w_buf_pc;
    logic [31:0] w_buf_instr;

    // Request is purely a function of the FSM so it stays stable under backpressure.
    assign imem_req_valid = (r_state == ST_FETCH);
    assign imem_req_addr  = r_pc;

    assign w_accept    = imem_req_valid && imem_req_ready;
    assign w_resp_wait = (r_state == ST_WAIT) && imem_resp_valid;
    assign w_buf_load  = w_resp_wait && !IF_ID_write && !redirect_valid;
    assign w_buf_drain = (r_state == ST_HOLD) && IF_ID_write && !redirect_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            // A request is still in flight if one was just accepted or a
            // WAIT/DROP response has not yet arrived; its data must be dropped.
            if (w_accept ||
                (((r_state == ST_WAIT) || (r_state == ST_DROP)) && !imem_resp_valid)) begin
                w_state_next = ST_DROP;
            end else begin
                w_state_next = ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_FETCH: if (w_accept)        w_state_next = ST_WAIT;
                ST_WAIT:  if (imem_resp_valid) w_state_next = IF_ID_write ? ST_FETCH : ST_HOLD;
                ST_HOLD:  if (IF_ID_write)     w_state_next = ST_FETCH;
                ST_DROP:  if (imem_resp_valid) w_state_next = ST_FETCH;
                default:                       w_state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // PC and outstanding-request address
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_req_pc <= 32'd0;
        end else begin
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc & ~32'd3;
            end else if (w_accept) begin
                r_pc <= r_pc + c_pc_incr;
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register; instr is forced to NOP whenever a bubble is written
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'd0;
            if_id_instr <= c_nop_instr;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
            if_id_instr <= c_nop_instr;
        end else if (IF_ID_write) begin
            if (w_resp_wait) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= r_req_pc;
                if_id_instr <= imem_resp_data;
            end else if ((r_state == ST_HOLD) && w_buf_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= w_buf_pc;
                if_id_instr <= w_buf_instr;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= c_nop_instr;
            end
        end
    end

    fetch_hold_buffer u_hold_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_buf_load),
        .drain     (w_buf_drain),
        .clear     (redirect_valid),
        .in_pc     (r_req_pc),
        .in_instr  (imem_resp_data),
        .buf_valid (w_buf_valid),
        .buf_pc    (w_buf_pc),
        .buf_instr (w_buf_instr)
    );

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. A per-cycle
//               vector table drives the handshake/stall/redirect inputs and
//               lists the expected request and IF/ID values; a hand-written
//               sequence covers asynchronous reset with a late response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        if_id_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int checks;
    int errors;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .IF_ID_write     (if_id_write),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        rsv;
        logic [31:0] rdata;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs(input int cyc, input logic e_rqv, input logic [31:0] e_addr,
                                 input logic e_iv, input logic [31:0] e_ipc,
                                 input logic [31:0] e_instr);
        check("req_valid", cyc, {31'd0, imem_req_valid}, {31'd0, e_rqv});
        if (e_rqv) check("req_addr", cyc, imem_req_addr, e_addr);
        check("if_id_valid", cyc, {31'd0, if_id_valid}, {31'd0, e_iv});
        if (e_iv) check("if_id_pc", cyc, if_id_pc, e_ipc);
        check("if_id_instr", cyc, if_id_instr, e_iv ? e_instr : c_nop);
    endtask

    task automatic drive(input logic w, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input logic rsv, input logic [31:0] rdata);
        if_id_write     = w;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_req_ready  = rdy;
        imem_resp_valid = rsv;
        imem_resp_data  = rdata;
    endtask

    task automatic add(input logic w, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic rsv, input logic [31:0] rdata,
                       input logic e_rqv, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_ipc, input logic [31:0] e_instr);
        vq.push_back('{w, rv, rpc, rdy, rsv, rdata, e_rqv, e_addr, e_iv, e_ipc, e_instr});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        //   w  rv rpc            rdy rsv rdata           rqv addr          iv ipc           instr
        // Stream 0x0, 0x4, 0x8 with k=1
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,        0, 32'h0,        c_nop);        // c0
        add(1, 0, 32'h0,          0, 1, 32'h0010_0093,  0, 32'h0,        0, 32'h0,        c_nop);        // c1
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,        1, 32'h0,        32'h0010_0093);// c2
        add(1, 0, 32'h0,          0, 1, 32'h0020_0113,  0, 32'h0,        0, 32'h0,        c_nop);        // c3
        // Backpressure on 0x8 for 3 cycles
        add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,        1, 32'h4,        32'h0020_0113);// c4
        add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,        0, 32'h0,        c_nop);        // c5
        add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,        0, 32'h0,        c_nop);        // c6
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8,        0, 32'h0,        c_nop);        // c7
        add(1, 0, 32'h0,          0, 1, 32'h0030_0193,  0, 32'h0,        0, 32'h0,        c_nop);        // c8
        // Stall capture of 0xC
        add(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hC,        1, 32'h8,        32'h0030_0193);// c9
        add(0, 0, 32'h0,          0, 1, 32'h00A0_0093,  0, 32'h0,        1, 32'h8,        32'h0030_0193);// c10
        add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        1, 32'h8,        32'h0030_0193);// c11
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h10,       1, 32'hC,        32'h00A0_0093);// c12
        // Redirect in WAIT (0x10 outstanding) to 0x100
        add(1, 1, 32'h100,        0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        c_nop);        // c13
        add(1, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  0, 32'h0,        0, 32'h0,        c_nop);        // c14
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,      0, 32'h0,        c_nop);        // c15
        add(1, 0, 32'h0,          0, 1, 32'h0050_0293,  0, 32'h0,        0, 32'h0,        c_nop);        // c16
        // Redirect during stall with buffer full, unaligned target 0x203
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,      1, 32'h100,      32'h0050_0293);// c17
        add(0, 0, 32'h0,          0, 1, 32'h0060_0313,  0, 32'h0,        0, 32'h0,        c_nop);        // c18
        add(0, 1, 32'h203,        0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        c_nop);        // c19
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,      0, 32'h0,        c_nop);        // c20
        add(1, 0, 32'h0,          0, 1, 32'h0070_0393,  0, 32'h0,        0, 32'h0,        c_nop);        // c21
        // Redirect in the same cycle a request is accepted
        add(1, 1, 32'h300,        1, 0, 32'h0,          1, 32'h204,      1, 32'h200,      32'h0070_0393);// c22
        add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        c_nop);        // c23
        add(1, 0, 32'h0,          0, 1, 32'hBAD0_0001,  0, 32'h0,        0, 32'h0,        c_nop);        // c24
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h300,      0, 32'h0,        c_nop);        // c25
        // Redirect coincident with response; target at top of address space
        add(1, 1, 32'hFFFF_FFFC,  0, 1, 32'hBAD0_0002,  0, 32'h0,        0, 32'h0,        c_nop);        // c26
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC,0, 32'h0,        c_nop);        // c27
        add(1, 0, 32'h0,          0, 1, 32'h0080_0413,  0, 32'h0,        0, 32'h0,        c_nop);        // c28
        add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,        1, 32'hFFFF_FFFC,32'h0080_0413);// c29
        add(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,        0, 32'h0,        c_nop);        // c30

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs(-1, 1'b1, 32'h0, 1'b0, 32'h0, c_nop);
        check("if_id_pc_reset", -1, if_id_pc, 32'h0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].w, vq[i].rv, vq[i].rpc, vq[i].rdy, vq[i].rsv, vq[i].rdata);
            #1;
            check_outputs(i, vq[i].e_rqv, vq[i].e_addr, vq[i].e_iv, vq[i].e_ipc, vq[i].e_instr);
        end

        // After c30 the unit is in WAIT with 0x0 outstanding: assert reset mid-cycle.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(100, 1'b1, 32'h0, 1'b0, 32'h0, c_nop);
        check("if_id_pc_async_reset", 100, if_id_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // Late response to the pre-reset request arrives in FETCH: ignored.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0003);
        #1;
        check_outputs(101, 1'b1, 32'h0, 1'b0, 32'h0, c_nop);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check_outputs(102, 1'b1, 32'h0, 1'b0, 32'h0, c_nop);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0090_0493);
        #1;
        check_outputs(103, 1'b0, 32'h0, 1'b0, 32'h0, c_nop);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_outputs(104, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0090_0493);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
